// File: rtl/run_monitor_pkg.sv
// Shared types and constants for the end-of-run monitor.
package run_monitor_pkg;

    // Monitor phases. The top level walks RUN -> FLUSH -> REQ -> DONE.
    // It stays in REQ for the whole dump, while dump_sequencer cycles
    // through its own REQ/CAP/OUT phases for each word.
    typedef enum logic [2:0] {RUN, FLUSH, REQ, CAP, OUT, DONE} state_t;

    // Per-word phases of the dump loop.
    typedef enum logic [1:0] {SEQ_IDLE, SEQ_REQ, SEQ_CAP, SEQ_OUT} seq_t;

    // The all-zero NOP ends a program unless a build overrides it.
    localparam logic [31:0] TERM_INSTR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/run_monitor_if.sv
// Data-memory read port and dump stream between the monitor and its environment.
interface run_monitor_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 128
);
    logic              memRdEn;
    logic [ADDR_W-1:0] memRdAddr;
    logic [DATA_W-1:0] memRdData;
    logic              dumpValid;
    logic              dumpReady;
    logic [ADDR_W-1:0] dumpAddr;
    logic [DATA_W-1:0] dumpData;

    modport master (
        output memRdEn, memRdAddr, dumpValid, dumpAddr, dumpData,
        input  memRdData, dumpReady
    );

    modport slave (
        input  memRdEn, memRdAddr, dumpValid, dumpAddr, dumpData,
        output memRdData, dumpReady
    );
endinterface

// File: rtl/run_monitor_dump_sequencer.sv
// Walks dmem words 0..DUMP_DEPTH-1: read, capture, then hold until accepted.
module dump_sequencer
    import run_monitor_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 128,
    parameter int DUMP_DEPTH = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              memRdEn,
    output logic [ADDR_W-1:0] memRdAddr,
    input  logic [DATA_W-1:0] memRdData,
    output logic              dumpValid,
    input  logic              dumpReady,
    output logic [ADDR_W-1:0] dumpAddr,
    output logic [DATA_W-1:0] dumpData,
    output logic              lastAck
);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DUMP_DEPTH - 1);

    seq_t              phase, phaseNext;
    logic [ADDR_W-1:0] idx;
    logic              accept;

    assign accept    = (phase == SEQ_OUT) && dumpReady;
    assign lastAck   = accept && (idx == LAST_IDX);
    // The index is itself a register, so the read address needs no extra flop.
    assign memRdAddr = idx;

    // Phase register.
    always_ff @(posedge clk) begin
        if (reset) phase <= SEQ_IDLE;
        else       phase <= phaseNext;
    end

    // One word takes REQ, CAP, then OUT until the consumer takes it.
    always_comb begin
        phaseNext = phase;
        case (phase)
            SEQ_IDLE: if (start) phaseNext = SEQ_REQ;
            SEQ_REQ:  phaseNext = SEQ_CAP;
            SEQ_CAP:  phaseNext = SEQ_OUT;
            SEQ_OUT:  if (dumpReady) phaseNext = lastAck ? SEQ_IDLE : SEQ_REQ;
            default:  phaseNext = SEQ_IDLE;
        endcase
    end

    // Read strobe, index and output register; the word holds until accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx       <= '0;
            memRdEn   <= 1'b0;
            dumpValid <= 1'b0;
            dumpAddr  <= '0;
            dumpData  <= '0;
        end else begin
            memRdEn <= (phaseNext == SEQ_REQ);
            if (phase == SEQ_CAP) begin
                dumpData  <= memRdData;
                dumpAddr  <= idx;
                dumpValid <= 1'b1;
            end
            if (accept) begin
                dumpValid <= 1'b0;
                // Stop on the last word so the index never wraps.
                if (!lastAck) idx <= idx + ADDR_W'(1);
            end
        end
    end
endmodule

// File: rtl/run_monitor.sv
// End-of-run monitor: counts run/stall cycles, spots the end of the program
// or a timeout, waits for the pipeline to drain, then dumps data memory.
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int INSTR_W        = 32,
    parameter int DATA_W         = 128,
    parameter int ADDR_W         = 8,
    parameter int DUMP_DEPTH     = 64,
    parameter int FLUSH_CYCLES   = 5,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 0,
    parameter logic [INSTR_W-1:0] TERM_INSTR = INSTR_W'(TERM_INSTR_DEFAULT)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [INSTR_W-1:0] instruction,
    input  logic               instrValid,
    run_monitor_if.master      bus,
    output logic               cpuHold,
    output logic [CNT_W-1:0]   cycleCount,
    output logic [CNT_W-1:0]   stallCount,
    output logic               timedOut,
    output logic               done
);
    localparam int             FW         = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FW-1:0]  FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam bit             TO_EN      = (TIMEOUT_CYCLES != 0);

    state_t        state, stateNext;
    logic [FW-1:0] flushCnt;
    logic          termHit, toHit, seqStart, lastAck;

    assign termHit = instrValid && (instruction == TERM_INSTR);
    assign toHit   = TO_EN && (cycleCount == TO_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= stateNext;
    end

    // Run/flush control; the sequencer owns the per-word dump phases.
    always_comb begin
        stateNext = state;
        seqStart  = 1'b0;
        case (state)
            RUN:     if (termHit || toHit) stateNext = FLUSH;
            FLUSH:   if (flushCnt == '0) begin
                         stateNext = REQ;
                         seqStart  = 1'b1;
                     end
            REQ:     if (lastAck) stateNext = DONE;
            default: stateNext = state;
        endcase
    end

    // Saturating run/stall counters, timeout flag and flush countdown.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycleCount <= '0;
            stallCount <= '0;
            timedOut   <= 1'b0;
            flushCnt   <= '0;
        end else if (state == RUN) begin
            if (cycleCount != '1) cycleCount <= cycleCount + CNT_W'(1);
            if (!instrValid && stallCount != '1) stallCount <= stallCount + CNT_W'(1);
            if (termHit || toHit) begin
                flushCnt <= FLUSH_LOAD;
                // A real terminator wins over a coincident timeout.
                timedOut <= !termHit;
            end
        end else if (state == FLUSH && flushCnt != '0) begin
            flushCnt <= flushCnt - FW'(1);
        end
    end

    // CPU hold from the first read request onwards; done after the last handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpuHold <= 1'b0;
            done    <= 1'b0;
        end else begin
            if (seqStart) cpuHold <= 1'b1;
            if (state == REQ && lastAck) done <= 1'b1;
        end
    end

    dump_sequencer #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .DUMP_DEPTH (DUMP_DEPTH)
    ) uSeq (
        .clk       (clk),
        .reset     (reset),
        .start     (seqStart),
        .memRdEn   (bus.memRdEn),
        .memRdAddr (bus.memRdAddr),
        .memRdData (bus.memRdData),
        .dumpValid (bus.dumpValid),
        .dumpReady (bus.dumpReady),
        .dumpAddr  (bus.dumpAddr),
        .dumpData  (bus.dumpData),
        .lastAck   (lastAck)
    );
endmodule

// File: tb/tb_run_monitor.sv
// Randomized bench for run_monitor: two instances (default build, and a
// 256-word dump with a 100-cycle timeout) checked against a stimulus-list model.
module tb_run_monitor;
    localparam int FLUSH = 5;
    localparam int DEPTH [2] = '{64, 256};
    localparam int TOUT  [2] = '{0, 100};

    typedef struct packed {
        logic        v;
        logic [31:0] ins;
    } stim_t;

    logic         clk;
    logic         rst   [2];
    logic [31:0]  instr [2];
    logic         iv    [2];
    logic         rdy   [2];
    logic         ren   [2];
    logic [7:0]   raddr [2];
    logic         dv    [2];
    logic [7:0]   daddr [2];
    logic [127:0] ddata [2];
    logic         hold  [2];
    logic [31:0]  cyc   [2];
    logic [31:0]  stl   [2];
    logic         to    [2];
    logic         dn    [2];

    logic [127:0] mem [2][256];
    logic [127:0] rdq0, rdq1;

    int nCmp = 0;
    int nErr = 0;

    run_monitor_if #(.ADDR_W(8), .DATA_W(128)) bus0 ();
    run_monitor_if #(.ADDR_W(8), .DATA_W(128)) bus1 ();

    assign bus0.dumpReady = rdy[0];
    assign bus1.dumpReady = rdy[1];
    assign bus0.memRdData = rdq0;
    assign bus1.memRdData = rdq1;
    assign ren[0] = bus0.memRdEn;   assign ren[1] = bus1.memRdEn;
    assign raddr[0] = bus0.memRdAddr; assign raddr[1] = bus1.memRdAddr;
    assign dv[0] = bus0.dumpValid;  assign dv[1] = bus1.dumpValid;
    assign daddr[0] = bus0.dumpAddr; assign daddr[1] = bus1.dumpAddr;
    assign ddata[0] = bus0.dumpData; assign ddata[1] = bus1.dumpData;

    run_monitor #(
        .INSTR_W(32), .DATA_W(128), .ADDR_W(8), .DUMP_DEPTH(64),
        .FLUSH_CYCLES(FLUSH), .CNT_W(32), .TIMEOUT_CYCLES(0)
    ) dut0 (
        .clk(clk), .reset(rst[0]), .instruction(instr[0]), .instrValid(iv[0]),
        .bus(bus0), .cpuHold(hold[0]), .cycleCount(cyc[0]), .stallCount(stl[0]),
        .timedOut(to[0]), .done(dn[0])
    );

    run_monitor #(
        .INSTR_W(32), .DATA_W(128), .ADDR_W(8), .DUMP_DEPTH(256),
        .FLUSH_CYCLES(FLUSH), .CNT_W(32), .TIMEOUT_CYCLES(100)
    ) dut1 (
        .clk(clk), .reset(rst[1]), .instruction(instr[1]), .instrValid(iv[1]),
        .bus(bus1), .cpuHold(hold[1]), .cycleCount(cyc[1]), .stallCount(stl[1]),
        .timedOut(to[1]), .done(dn[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous dmem: data the cycle after the strobe, junk otherwise.
    always @(posedge clk) begin
        if (bus0.memRdEn) rdq0 <= mem[0][bus0.memRdAddr];
        else              rdq0 <= {$urandom, $urandom, $urandom, $urandom};
        if (bus1.memRdEn) rdq1 <= mem[1][bus1.memRdAddr];
        else              rdq1 <= {$urandom, $urandom, $urandom, $urandom};
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nCmp++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chkResetVals(input int d);
        chk("rst_memRdEn", ren[d], 0);
        chk("rst_memRdAddr", raddr[d], 0);
        chk("rst_cpuHold", hold[d], 0);
        chk("rst_dumpValid", dv[d], 0);
        chk("rst_dumpAddr", daddr[d], 0);
        chk("rst_dumpData", ddata[d], 0);
        chk("rst_cycleCount", cyc[d], 0);
        chk("rst_stallCount", stl[d], 0);
        chk("rst_timedOut", to[d], 0);
        chk("rst_done", dn[d], 0);
    endtask

    // mode: 0 all valid, 1 every third cycle stalled, 2 random stalls.
    // rdyMode: 0 random backpressure, 1 ready tied high. abortAt: reset while
    // that word is on the dump port (-1 for none).
    task automatic scenario(input int d, input bit doRst, input int n, input int mode,
                            input bit addTerm, input int rdyMode, input int abortAt);
        stim_t q[$];
        stim_t s;
        int exitK, expStl, e, elapsed, budget;
        bit expTo, hs;
        logic [31:0] frzCyc, frzStl;

        if (doRst) begin
            rst[d] = 1'b1; iv[d] = 1'b0; instr[d] = '0; rdy[d] = 1'b0;
            tick(); tick();
            chkResetVals(d);
            rst[d] = 1'b0;
        end

        for (int k = 0; k < n; k++) begin
            case (mode)
                0:       s.v = 1'b1;
                1:       s.v = (k % 3 != 2);
                default: s.v = ($urandom_range(3) != 0);
            endcase
            if (s.v) s.ins = $urandom | 32'h100;
            else     s.ins = ($urandom_range(1) == 0) ? 32'h0 : $urandom;
            q.push_back(s);
        end
        if (addTerm) begin
            s.v = 1'b1; s.ins = 32'h0;
            q.push_back(s);
        end

        // Reference: first valid terminator, or the TOUT-th run cycle.
        exitK = -1; expTo = 1'b0;
        for (int k = 0; k < q.size(); k++) begin
            if (q[k].v && q[k].ins == 32'h0) begin exitK = k; expTo = 1'b0; break; end
            if (TOUT[d] != 0 && k + 1 == TOUT[d]) begin exitK = k; expTo = 1'b1; break; end
        end
        if (exitK < 0) begin
            chk("model_no_exit", 0, 1);
            return;
        end
        expStl = 0;
        for (int k = 0; k <= exitK; k++) if (!q[k].v) expStl++;

        for (int k = 0; k <= exitK; k++) begin
            iv[d] = q[k].v; instr[d] = q[k].ins;
            tick();
        end
        chk("cycleCount", cyc[d], exitK + 1);
        chk("stallCount", stl[d], expStl);
        chk("timedOut", to[d], expTo);
        frzCyc = cyc[d]; frzStl = stl[d];

        // Flush window, with terminators thrown in that must be ignored.
        for (int j = 0; j <= FLUSH + 2; j++) begin
            if (j > 0) begin
                iv[d] = $urandom_range(1);
                instr[d] = ($urandom_range(1) == 0) ? 32'h0 : $urandom;
                tick();
            end
            chk("flush_cpuHold", hold[d], j >= FLUSH);
            chk("flush_dumpValid", dv[d], j >= FLUSH + 2);
            chk("flush_memRdEn", ren[d], j == FLUSH);
        end
        chk("frozen_cycleCount", cyc[d], frzCyc);
        chk("frozen_stallCount", stl[d], frzStl);

        e = 0; elapsed = FLUSH + 2; budget = 20 * DEPTH[d] + 50;
        while (e < DEPTH[d] && budget > 0) begin
            if (dv[d]) begin
                chk("dumpAddr", daddr[d], e);
                chk("dumpData", ddata[d], mem[d][e]);
            end
            chk("dump_cpuHold", hold[d], 1);
            chk("dump_done", dn[d], 0);
            if (abortAt >= 0 && e == abortAt && dv[d]) begin
                rst[d] = 1'b1; rdy[d] = 1'b0;
                tick();
                chkResetVals(d);
                rst[d] = 1'b0;
                return;
            end
            rdy[d] = (rdyMode == 1) ? 1'b1 : 1'($urandom_range(1));
            hs = dv[d] && rdy[d];
            tick();
            elapsed++; budget--;
            if (hs) e++;
        end
        if (e < DEPTH[d]) chk("dump_budget", e, DEPTH[d]);
        chk("done_rise", dn[d], 1);
        chk("done_dumpValid", dv[d], 0);
        if (rdyMode == 1) chk("dump_time", elapsed, FLUSH + 3 * DEPTH[d]);

        // Terminal: nothing more comes out, counters hold.
        for (int j = 0; j < 6; j++) begin
            rdy[d] = $urandom_range(1); iv[d] = 1'b1; instr[d] = 32'h0;
            tick();
            chk("term_dumpValid", dv[d], 0);
            chk("term_memRdEn", ren[d], 0);
            chk("term_done", dn[d], 1);
        end
        chk("term_cycleCount", cyc[d], frzCyc);
        chk("term_timedOut", to[d], expTo);
        chk("term_dumpAddr", daddr[d], DEPTH[d] - 1);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; iv[d] = 1'b0; instr[d] = '0; rdy[d] = 1'b0;
            for (int i = 0; i < 256; i++)
                mem[d][i] = {$urandom, $urandom, $urandom, 32'(i)};
        end
        rdq0 = '0; rdq1 = '0;

        scenario(0, 1, 20, 0, 1, 0, -1);   // 20 valid + terminator, backpressure
        scenario(0, 1, 30, 1, 1, 1, -1);   // every third cycle stalled, ready high
        scenario(0, 1, 50, 2, 1, 0, 5);    // reset while a word is on the port
        scenario(0, 0, 15, 2, 1, 0, -1);   // runs again from 0 without extra reset
        scenario(1, 1, 150, 2, 0, 0, -1);  // timeout, 256-word dump
        scenario(1, 1, 99, 0, 1, 1, -1);   // terminator coincides with limit

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
